// File: rtl/bpred_bht_btb_pkg.sv
// Shared constants, FSM state type and saturating-counter helpers for the
// bimodal/gshare branch predictor.
package bpred_bht_btb_pkg;

    localparam int XLEN         = 32;
    localparam int INSN_ALIGN   = 2;
    localparam int CTR_MAX_BITS = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic ctr_t ctr_init(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t ctr_sat(input ctr_t ctr, input logic taken, input int bits);
        ctr_t top;
        top = ctr_t'((1 << bits) - 1);
        if (taken) begin
            return (ctr == top) ? ctr : ctr + ctr_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bpred_table.sv
// 1-read/1-write storage array: synchronous write, asynchronous read.
// The predictor builds its BHT and BTB fields out of instances of this block.
module bpred_table #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the owner initialises it by sweeping writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bpred_bht_btb.sv
// Branch predictor: BHT of saturating counters plus direct-mapped BTB, with
// optional gshare history, an init sweep FSM and registered prediction outputs.
module bpred_bht_btb
    import bpred_bht_btb_pkg::*;
#(
    parameter  int ENTRIES  = 64,
    parameter  int CTR_BITS = 2,
    parameter  int TAG_BITS = 8,
    parameter  int GHR_BITS = 0,
    localparam int IDXW     = $clog2(ENTRIES),
    localparam int GW       = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_valid,
    input  logic [XLEN-1:0] lk_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [IDXW-1:0] pred_idx,
    output logic [GW-1:0]   pred_ghr,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [IDXW-1:0] upd_idx,
    input  logic [GW-1:0]   upd_ghr,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic            ready
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

    state_e              state, state_nxt;
    logic [IDXW-1:0]     sweep_idx;
    logic                sweeping;
    logic [GW-1:0]       ghr, ghr_nxt;

    logic [IDXW-1:0]     lk_btb_idx, lk_bht_idx, upd_btb_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    logic                lk_en, upd_en;
    logic                lk_hit, lk_taken;
    logic [XLEN-1:0]     lk_target;

    logic [CTR_BITS-1:0] lk_ctr, upd_ctr, ctr_wdata;
    logic [IDXW-1:0]     ctr_waddr;
    logic                ctr_we;
    logic [TAG_BITS:0]   lk_vt, vt_wdata;
    logic                vt_we;
    logic [XLEN-1:0]     lk_tgt;
    logic                tgt_we;

    assign lk_btb_idx  = lk_pc[INSN_ALIGN +: IDXW];
    assign lk_tag      = lk_pc[INSN_ALIGN + IDXW +: TAG_BITS];
    assign upd_btb_idx = upd_pc[INSN_ALIGN +: IDXW];
    assign upd_tag     = upd_pc[INSN_ALIGN + IDXW +: TAG_BITS];
    assign lk_en       = lk_valid && ready;
    assign upd_en      = upd_valid && ready;

    always_comb begin
        if (GHR_BITS > 0) begin
            lk_bht_idx = lk_btb_idx ^ IDXW'(ghr);
        end else begin
            lk_bht_idx = lk_btb_idx;
        end
    end

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_INIT: if (sweep_idx == IDXW'(ENTRIES - 1)) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        sweeping = (state == ST_INIT);
        ready    = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) begin
            sweep_idx <= '0;
        end else if (sweeping) begin
            sweep_idx <= sweep_idx + IDXW'(1);
        end
    end

    // ---------------- Tables ----------------
    // The counter field needs a read for the lookup and one for the update's
    // read-modify-write, so it is held in two identically written copies.
    assign ctr_we    = sweeping || upd_en;
    assign ctr_waddr = sweeping ? sweep_idx : upd_idx;
    assign ctr_wdata = sweeping ? CTR_INIT
                                : CTR_BITS'(ctr_sat(ctr_t'(upd_ctr), upd_taken, CTR_BITS));

    bpred_table #(.DEPTH(ENTRIES), .WIDTH(CTR_BITS)) u_ctr_lk (
        .clk(clk), .we(ctr_we), .waddr(ctr_waddr), .wdata(ctr_wdata),
        .raddr(lk_bht_idx), .rdata(lk_ctr)
    );

    bpred_table #(.DEPTH(ENTRIES), .WIDTH(CTR_BITS)) u_ctr_upd (
        .clk(clk), .we(ctr_we), .waddr(ctr_waddr), .wdata(ctr_wdata),
        .raddr(upd_idx), .rdata(upd_ctr)
    );

    assign vt_we    = sweeping || (upd_en && upd_taken);
    assign vt_wdata = sweeping ? '0 : {1'b1, upd_tag};

    bpred_table #(.DEPTH(ENTRIES), .WIDTH(TAG_BITS + 1)) u_valid_tag (
        .clk(clk), .we(vt_we), .waddr(sweeping ? sweep_idx : upd_btb_idx), .wdata(vt_wdata),
        .raddr(lk_btb_idx), .rdata(lk_vt)
    );

    assign tgt_we = upd_en && upd_taken;

    bpred_table #(.DEPTH(ENTRIES), .WIDTH(XLEN)) u_target (
        .clk(clk), .we(tgt_we), .waddr(upd_btb_idx), .wdata(upd_target),
        .raddr(lk_btb_idx), .rdata(lk_tgt)
    );

    assign lk_hit    = lk_vt[TAG_BITS] && (lk_vt[TAG_BITS-1:0] == lk_tag);
    assign lk_taken  = lk_hit && lk_ctr[CTR_BITS-1];
    assign lk_target = lk_taken ? lk_tgt : lk_pc + XLEN'(4);

    // ---------------- Global history ----------------
    // A mispredict repair overrides any speculative shift from the same cycle.
    always_comb begin
        ghr_nxt = ghr;
        if (GHR_BITS > 0) begin
            if (upd_en && upd_mispredict) begin
                ghr_nxt = GW'({upd_ghr, upd_taken});
            end else if (lk_en && lk_hit) begin
                ghr_nxt = GW'({ghr, lk_taken});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_nxt;
        end
    end

    // ---------------- Registered prediction ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_idx    <= '0;
            pred_ghr    <= '0;
        end else begin
            pred_valid <= lk_en;
            if (lk_en) begin
                pred_taken  <= lk_taken;
                pred_target <= lk_target;
                pred_idx    <= lk_bht_idx;
                pred_ghr    <= ghr;
            end
        end
    end

    // Address bits outside index/tag, and history inputs in bimodal mode, are don't-care.
    logic unused_bits;
    assign unused_bits = ^{lk_pc, upd_pc, upd_ghr, upd_mispredict};

endmodule

// File: doc/bpred_bht_btb.md
BPRED_BHT_BTB -- requirements
Module: bpred_bht_btb

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning BHT/BTB entry count; power of two, 4..1024.
REQ-002 SHALL have parameter CTR_BITS, default 2, meaning saturating-counter width; 1..4.
REQ-003 SHALL have parameter TAG_BITS, default 8, meaning BTB tag width taken from pc above the index.
REQ-004 SHALL have parameter GHR_BITS, default 0, meaning global history length; 0 = bimodal, >0 = gshare, at most log2(ENTRIES).
REQ-005 SHALL have clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have lk_valid / lk_pc, input, 1 / 32, meaning fetch-stage lookup request and its pc.
REQ-008 SHALL have pred_valid / pred_taken / pred_target / pred_idx / pred_ghr, output, 1 / 1 / 32 / log2(ENTRIES) / max(GHR_BITS,1), meaning the registered prediction and the metadata carried down the pipe.
REQ-009 SHALL have upd_valid / upd_pc / upd_idx / upd_ghr / upd_taken / upd_target / upd_mispredict, input, 1 / 32 / log2(ENTRIES) / max(GHR_BITS,1) / 1 / 32 / 1, meaning exe-stage resolution of one conditional branch.
REQ-010 SHALL have ready, output, 1, meaning high when initialisation is complete.

Function
REQ-011 SHALL use IDXW = log2(ENTRIES), btb_idx = lk_pc[2+:IDXW], and tag = lk_pc[2+IDXW+:TAG_BITS].
REQ-012 SHALL form bht_idx = btb_idx XOR (GHR zero-extended to IDXW) when GHR_BITS>0, else bht_idx = btb_idx.
REQ-013 SHALL register one-cycle-latency outputs when lk_valid && ready: pred_valid=1; hit = valid[btb_idx] && tag match; pred_taken = hit && counter MSB; pred_target = target[btb_idx] if pred_taken, else lk_pc+4; pred_idx = bht_idx; pred_ghr = GHR before this lookup's shift.
REQ-014 SHALL, when lk_valid=0 or ready=0, set pred_valid=0 on the next cycle and hold the other pred_* outputs.
REQ-015 SHALL, on upd_valid, increment counter[upd_idx] if upd_taken, else decrement it, saturating at 0 and 2^CTR_BITS-1.
REQ-016 SHALL, on upd_valid && upd_taken, write the BTB at upd_pc's index with valid=1, tag from upd_pc, and target=upd_target; a not-taken update SHALL leave the BTB unchanged.
REQ-017 SHALL, with GHR_BITS>0, shift pred_taken into the GHR LSB on each lookup that hits the BTB.
REQ-018 SHALL, on upd_valid && upd_mispredict, set GHR = {upd_ghr[GHR_BITS-2:0], upd_taken}; this SHALL take priority over a same-cycle speculative shift.
REQ-019 SHALL, when a lookup and an update hit the same entry in the same cycle, give the lookup the pre-update contents (read-before-write, no bypass).
REQ-020 SHALL ignore upd_valid while ready=0.
REQ-021 SHALL implement an FSM with states INIT and RUN: INIT sweeps an index counter 0..ENTRIES-1, one entry per cycle, clearing valid and setting the counter to 2^(CTR_BITS-1)-1 (weakly not-taken); after the last entry it enters RUN; ready=1 only in RUN.

Reset
REQ-022 SHALL, on rst, enter INIT with sweep index 0, GHR=0, ready=0, pred_valid=0, pred_taken=0, pred_target=0, pred_idx=0, and pred_ghr=0.
REQ-023 SHALL, when rst is asserted mid-sweep or in RUN, restart the sweep from index 0; table contents are not required to be reset other than by the sweep.
REQ-024 SHALL make ready rise exactly ENTRIES cycles after rst deasserts.

Structure
REQ-025 SHALL take the shared package for counter-init and saturate helper functions, the pc-slicing constants (instruction alignment 2), and the XLEN=32 constant.
REQ-026 SHALL place BHT and BTB storage in one sub-module, bpred_table, a parametrised 1-read/1-write synchronous-write array with asynchronous read, instantiated once per field (counter, valid+tag, target).
REQ-027 SHALL keep the FSM, GHR, and output registers in bpred_bht_btb.

Verification
REQ-028 SHALL cover: rst for 1 cycle with ENTRIES=64 -> ready=0 for 64 cycles then 1; a lookup during INIT -> pred_valid=0.
REQ-029 SHALL cover: after init, lookup pc=0x100 -> pred_taken=0, pred_target=0x104; update pc=0x100 taken to 0x200 once -> counter 01->10; next lookup of 0x100 -> pred_taken=1, pred_target=0x200.
REQ-030 SHALL cover: CTR_BITS=2 with 4 taken updates -> counter 11 (saturated); then 2 not-taken -> 01 and pred_taken=0 while the BTB entry stays valid.
REQ-031 SHALL cover: aliasing, where pc=0x100 is trained taken, then lookup of pc=0x100+4*ENTRIES (different tag) -> pred_taken=0, pred_target=pc+4.
REQ-032 SHALL cover: GHR_BITS=4 with GHR=0b1010 and a mispredict update with upd_ghr=0b0011, upd_taken=1 plus a same-cycle hitting lookup -> GHR=0b0111.
REQ-033 SHALL cover: a same-cycle lookup and update to the same index -> prediction reflects old counter; rst asserted at sweep index 30 -> ready rises 64 cycles after the new deassertion.
